// File: rtl/stage_id_pipe.sv
// Purpose: MIPS-style decode stage; decodes, reads the register file and registers results into ID/EX.
// Latency: one cycle from instr/pc_id to the EX outputs; register-file read and WB bypass are combinational.
// Backpressure: ready_out drops for one cycle on a load-use hazard (a bubble goes to EX); flush overrides it.
module stage_id_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int ZERO_REG  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_id,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ready_out,
  output logic              valid_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        rd_ex,
  output logic [3:0]        alu_op,
  output logic              alu_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              branch,
  output logic              branch_ne,
  output logic              jump,
  output logic              illegal_ex
);

  localparam int ADDR_W = $clog2(REG_COUNT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_LUI   = 4'b1000;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  logic [5:0]        opcode;
  logic [3:0]        decAluOp;
  logic              decAluSrc, decMemRead, decMemWrite, decRegWrite, decMemToReg;
  logic              decBranch, decBranchNe, decJump;
  logic              decRtUsed, decIsR, decZeroExt, decIllegal;

  logic [DATA_W-1:0] regFile [REG_COUNT];
  logic [ADDR_W-1:0] rsIdx, rtIdx, wbIdx;
  logic              wbEn;
  logic [DATA_W-1:0] rsRead, rtRead, immExt;
  logic [4:0]        rdSel;
  logic              hz, loadBubble;

  assign opcode = instr[31:26];

  // Main decoder: control word per opcode; unknown opcodes leave every control at 0.
  always_comb begin
    decAluOp    = ALU_ADD;
    decAluSrc   = 1'b0;
    decMemRead  = 1'b0;
    decMemWrite = 1'b0;
    decRegWrite = 1'b0;
    decMemToReg = 1'b0;
    decBranch   = 1'b0;
    decBranchNe = 1'b0;
    decJump     = 1'b0;
    decRtUsed   = 1'b0;
    decIsR      = 1'b0;
    decZeroExt  = 1'b0;
    decIllegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decRegWrite = 1'b1;
        decAluOp    = ALU_FUNCT;
        decRtUsed   = 1'b1;
        decIsR      = 1'b1;
      end
      OP_LW: begin
        decAluSrc   = 1'b1;
        decMemRead  = 1'b1;
        decMemToReg = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_SW: begin
        decAluSrc   = 1'b1;
        decMemWrite = 1'b1;
        decRtUsed   = 1'b1;
      end
      OP_BEQ: begin
        decBranch = 1'b1;
        decAluOp  = ALU_SUB;
        decRtUsed = 1'b1;
      end
      OP_BNE: begin
        decBranch   = 1'b1;
        decBranchNe = 1'b1;
        decAluOp    = ALU_SUB;
        decRtUsed   = 1'b1;
      end
      OP_J: decJump = 1'b1;
      OP_ADDI: begin
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_ANDI: begin
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
        decAluOp    = ALU_AND;
        decZeroExt  = 1'b1;
      end
      OP_ORI: begin
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
        decAluOp    = ALU_OR;
        decZeroExt  = 1'b1;
      end
      OP_SLTI: begin
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
        decAluOp    = ALU_SLT;
      end
      OP_LUI: begin
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
        decAluOp    = ALU_LUI;
      end
      default: decIllegal = 1'b1;
    endcase
  end

  // Register addresses are 5 bits on the ports; only the low ADDR_W bits select a register.
  assign rsIdx = instr[21 +: ADDR_W];
  assign rtIdx = instr[16 +: ADDR_W];
  assign wbIdx = wb_addr[ADDR_W-1:0];
  assign wbEn  = wb_we && !((ZERO_REG != 0) && (wbIdx == '0));

  // Write-first read: a WB write to the same register is visible in the cycle it happens.
  assign rsRead = ((ZERO_REG != 0) && (rsIdx == '0)) ? '0 :
                  (wbEn && (wbIdx == rsIdx))          ? wb_data : regFile[rsIdx];
  assign rtRead = ((ZERO_REG != 0) && (rtIdx == '0)) ? '0 :
                  (wbEn && (wbIdx == rtIdx))          ? wb_data : regFile[rtIdx];

  assign immExt = decZeroExt ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                             : {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign rdSel  = decIsR ? instr[15:11] : instr[20:16];

  // A load in EX whose destination is a source here cannot forward in time; hold IF one cycle.
  assign hz = valid_in && valid_ex && mem_read && (rd_ex != 5'd0) &&
              ((rd_ex == instr[25:21]) || (decRtUsed && (rd_ex == instr[20:16])));
  assign ready_out  = reset || flush || !hz;
  assign loadBubble = flush || hz || !valid_in;

  // Register file storage; WB writes still land during stalls and flushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regFile[i] <= '0;
    end else if (wbEn) begin
      regFile[wbIdx] <= wb_data;
    end
  end

  // ID/EX boundary: bubble on flush/hazard/empty slot, otherwise capture the decoded instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_ex   <= 1'b0;
      illegal_ex <= 1'b0;
      pc_ex      <= '0;
      rs_data    <= '0;
      rt_data    <= '0;
      imm_ext    <= '0;
      rs_ex      <= '0;
      rt_ex      <= '0;
      rd_ex      <= '0;
      alu_op     <= ALU_ADD;
      alu_src    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
    end else if (loadBubble) begin
      valid_ex   <= 1'b0;
      illegal_ex <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_src    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
    end else begin
      valid_ex   <= !decIllegal;
      illegal_ex <= decIllegal;
      pc_ex      <= pc_id;
      rs_data    <= rsRead;
      rt_data    <= rtRead;
      imm_ext    <= immExt;
      rs_ex      <= instr[25:21];
      rt_ex      <= instr[20:16];
      rd_ex      <= rdSel;
      alu_op     <= decAluOp;
      alu_src    <= decAluSrc;
      mem_read   <= decMemRead;
      mem_write  <= decMemWrite;
      reg_write  <= decRegWrite;
      mem_to_reg <= decMemToReg;
      branch     <= decBranch;
      branch_ne  <= decBranchNe;
      jump       <= decJump;
    end
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
// Bench for stage_id_pipe: default 32x32 instance and a 64-bit/16-register instance share one stimulus.
// A behavioural model predicts both instances; directed literals pin the model to hand-computed values.
module tb_stage_id_pipe;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic [63:0] pcIn;
  logic        validIn;
  logic        flush;
  logic        wbWe;
  logic [4:0]  wbAddr;
  logic [63:0] wbData;

  logic        ready_out, valid_ex, illegal_ex;
  logic [31:0] pc_ex, rs_data, rt_data, imm_ext;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, jump;

  logic        ready64, valid64, illegal64;
  logic [63:0] pc64, rsData64, rtData64, imm64;
  logic [4:0]  rs64, rt64, rd64;
  logic [3:0]  aluOp64;
  logic        aluSrc64, memRead64, memWrite64, regWrite64, memToReg64, branch64, branchNe64, jump64;

  stage_id_pipe dut (
    .clock(clock), .reset(reset), .instr(instr), .pc_id(pcIn[31:0]), .valid_in(validIn),
    .flush(flush), .wb_we(wbWe), .wb_addr(wbAddr), .wb_data(wbData[31:0]),
    .ready_out(ready_out), .valid_ex(valid_ex), .pc_ex(pc_ex), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .branch_ne(branch_ne),
    .jump(jump), .illegal_ex(illegal_ex)
  );

  stage_id_pipe #(.DATA_W(64), .REG_COUNT(16), .ZERO_REG(1)) dut64 (
    .clock(clock), .reset(reset), .instr(instr), .pc_id(pcIn), .valid_in(validIn),
    .flush(flush), .wb_we(wbWe), .wb_addr(wbAddr), .wb_data(wbData),
    .ready_out(ready64), .valid_ex(valid64), .pc_ex(pc64), .rs_data(rsData64),
    .rt_data(rtData64), .imm_ext(imm64), .rs_ex(rs64), .rt_ex(rt64), .rd_ex(rd64),
    .alu_op(aluOp64), .alu_src(aluSrc64), .mem_read(memRead64), .mem_write(memWrite64),
    .reg_write(regWrite64), .mem_to_reg(memToReg64), .branch(branch64), .branch_ne(branchNe64),
    .jump(jump64), .illegal_ex(illegal64)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Control bit order: alu_src mem_read mem_write reg_write mem_to_reg branch branch_ne jump
  typedef struct packed {
    logic       ill;
    logic       zext;
    logic       rtUsed;
    logic       isR;
    logic [3:0] op;
    logic [7:0] ctl;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opc);
    dec_t d;
    d = '{ill: 1'b0, zext: 1'b0, rtUsed: 1'b0, isR: 1'b0, op: 4'b0010, ctl: 8'h00};
    case (opc)
      6'h00: begin d.ctl = 8'b0001_0000; d.op = 4'b1111; d.rtUsed = 1'b1; d.isR = 1'b1; end
      6'h23: d.ctl = 8'b1101_1000;
      6'h2B: begin d.ctl = 8'b1010_0000; d.rtUsed = 1'b1; end
      6'h04: begin d.ctl = 8'b0000_0100; d.op = 4'b0110; d.rtUsed = 1'b1; end
      6'h05: begin d.ctl = 8'b0000_0110; d.op = 4'b0110; d.rtUsed = 1'b1; end
      6'h02: d.ctl = 8'b0000_0001;
      6'h08: d.ctl = 8'b1001_0000;
      6'h0C: begin d.ctl = 8'b1001_0000; d.op = 4'b0000; d.zext = 1'b1; end
      6'h0D: begin d.ctl = 8'b1001_0000; d.op = 4'b0001; d.zext = 1'b1; end
      6'h0A: begin d.ctl = 8'b1001_0000; d.op = 4'b0111; end
      6'h0F: begin d.ctl = 8'b1001_0000; d.op = 4'b1000; end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  logic [31:0] rf32 [32];
  logic [63:0] rf64 [16];
  bit          modelOn = 1'b0;
  logic        eVld, eIll, eFull;
  logic [7:0]  eCtl;
  logic [3:0]  eOp;
  logic [4:0]  eRs, eRt, eRd;
  logic [63:0] ePc, eRs64, eRt64, eImm64;
  logic [31:0] eRs32, eRt32;

  function automatic bit expHz();
    dec_t d;
    d = decode(instr[31:26]);
    return validIn && eVld && eCtl[6] && (eRd != 5'd0) &&
           ((eRd == instr[25:21]) || (d.rtUsed && eRd == instr[20:16]));
  endfunction

  // Model advance: apply the WB write first, then read, so same-cycle writes are seen.
  always @(posedge clock) begin
    dec_t d;
    bit   hzNow;
    if (reset) begin
      for (int i = 0; i < 32; i++) rf32[i] = '0;
      for (int i = 0; i < 16; i++) rf64[i] = '0;
      eVld = 0; eIll = 0; eFull = 1; eCtl = '0; eOp = 4'b0010;
      eRs = '0; eRt = '0; eRd = '0; ePc = '0;
      eRs64 = '0; eRt64 = '0; eImm64 = '0; eRs32 = '0; eRt32 = '0;
      modelOn = 1'b1;
    end else begin
      d     = decode(instr[31:26]);
      hzNow = expHz();
      if (wbWe) begin
        if (wbAddr != 5'd0)      rf32[wbAddr]      = wbData[31:0];
        if (wbAddr[3:0] != 4'd0) rf64[wbAddr[3:0]] = wbData;
      end
      if (flush || hzNow || !validIn) begin
        eVld = 0; eIll = 0; eFull = 0; eCtl = '0;
      end else begin
        eVld   = !d.ill;
        eIll   = d.ill;
        eFull  = !d.ill;
        eCtl   = d.ill ? 8'h00 : d.ctl;
        eOp    = d.op;
        eRs    = instr[25:21];
        eRt    = instr[20:16];
        eRd    = d.isR ? instr[15:11] : instr[20:16];
        ePc    = pcIn;
        eRs32  = rf32[instr[25:21]];
        eRt32  = rf32[instr[20:16]];
        eRs64  = rf64[instr[24:21]];
        eRt64  = rf64[instr[19:16]];
        eImm64 = d.zext ? {48'h0, instr[15:0]} : {{48{instr[15]}}, instr[15:0]};
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clock) begin
    if (modelOn) begin
      logic expRdy;
      expRdy = reset || flush || !expHz();
      chk("ready_out", ready_out, expRdy);
      chk("ready_out64", ready64, expRdy);
      chk("valid_ex", valid_ex, eVld);
      chk("valid_ex64", valid64, eVld);
      chk("illegal_ex", illegal_ex, eIll);
      chk("illegal_ex64", illegal64, eIll);
      chk("controls", {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, jump}, eCtl);
      chk("controls64", {aluSrc64, memRead64, memWrite64, regWrite64, memToReg64, branch64, branchNe64, jump64}, eCtl);
      if (eFull) begin
        chk("alu_op", alu_op, eOp);
        chk("alu_op64", aluOp64, eOp);
        chk("regnums", {rs_ex, rt_ex, rd_ex}, {eRs, eRt, eRd});
        chk("regnums64", {rs64, rt64, rd64}, {eRs, eRt, eRd});
        chk("pc_ex", pc_ex, ePc[31:0]);
        chk("pc_ex64", pc64, ePc);
        chk("rs_data", rs_data, eRs32);
        chk("rt_data", rt_data, eRt32);
        chk("rs_data64", rsData64, eRs64);
        chk("rt_data64", rtData64, eRt64);
        chk("imm_ext", imm_ext, eImm64[31:0]);
        chk("imm_ext64", imm64, eImm64);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [63:0] pc);
    instr = i; pcIn = pc; validIn = 1'b1; flush = 1'b0; wbWe = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] v);
    wbWe = 1'b1; wbAddr = a; wbData = v;
  endtask

  // Present one instruction and hold it while the stage stalls (bounded).
  task automatic issue(input logic [31:0] i, input logic [63:0] pc);
    int guard;
    guard = 0;
    put(i, pc);
    #1;
    while (!ready_out && guard < 4) begin
      tick();
      #1;
      guard++;
    end
    chk("stall_bound", ready_out, 1'b1);
    tick();
  endtask

  logic [31:0] seqTab [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr = '0; pcIn = '0; validIn = 1'b0; flush = 1'b0;
    wbWe = 1'b0; wbAddr = '0; wbData = '0;
    tick(); tick();
    chk("rst_valid", valid_ex, 1'b0);
    chk("rst_aluop", alu_op, 4'b0010);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_pc", pc_ex, 32'h0);

    reset = 1'b0;
    wb(5'd1, 64'h10); tick();
    wb(5'd4, 64'h7);  tick();
    wbWe = 1'b0;

    // lw r2,4(r1)
    put(32'h8C220004, 64'h100); tick();
    chk("lw_valid", valid_ex, 1'b1);
    chk("lw_memread", mem_read, 1'b1);
    chk("lw_rd", rd_ex, 5'd2);
    chk("lw_imm", imm_ext, 32'h4);
    chk("lw_rs", rs_data, 32'h10);
    chk("lw_pc", pc_ex, 32'h100);

    // add r3,r2,r4 hits the load; WB of r2 arrives during the stall
    put(32'h00441820, 64'h104); #1;
    chk("hz_ready", ready_out, 1'b0);
    wb(5'd2, 64'h55); tick();
    chk("hz_bubble", valid_ex, 1'b0);
    wbWe = 1'b0; #1;
    chk("hz_release", ready_out, 1'b1);
    tick();
    chk("add_valid", valid_ex, 1'b1);
    chk("add_rs", rs_ex, 5'd2);
    chk("add_aluop", alu_op, 4'b1111);
    chk("add_rd", rd_ex, 5'd3);
    chk("add_replay", rs_data, 32'h55);

    // or r6,r5,r0 with same-cycle WB of r5
    put(32'h00A03025, 64'h108); wb(5'd5, 64'hDEADBEEF); tick();
    chk("bypass_rs", rs_data, 32'hDEADBEEF);
    chk("bypass_rt0", rt_data, 32'h0);
    put(32'h00003825, 64'h10C); wb(5'd0, 64'h1234); tick();
    chk("r0_read", rs_data, 32'h0);
    wbWe = 1'b0;

    // flush while a load-use hazard is present
    put(32'h8C220004, 64'h110); tick();
    put(32'h00441820, 64'h114); flush = 1'b1; #1;
    chk("flush_ready", ready_out, 1'b1);
    tick();
    chk("flush_bubble", valid_ex, 1'b0);
    flush = 1'b0; #1;
    chk("post_flush_ready", ready_out, 1'b1);
    tick();
    chk("post_flush_valid", valid_ex, 1'b1);

    // illegal opcode, then zero- and sign-extended immediates
    put(32'hFC000000, 64'h118); tick();
    chk("ill_flag", illegal_ex, 1'b1);
    chk("ill_valid", valid_ex, 1'b0);
    put(32'h30088000, 64'h11C); tick();
    chk("ill_oneshot", illegal_ex, 1'b0);
    chk("andi_imm", imm_ext, 32'h00008000);
    put(32'h20098000, 64'h120); tick();
    chk("addi_imm", imm_ext, 32'hFFFF8000);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFF8000);

    // 64-bit instance: wide sign extension and 5-bit address aliasing
    put(32'h2009FFFF, 64'h1_0000_0124); wb(5'h13, 64'hABCD); tick();
    chk("imm64_ones", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("pc64_wide", pc64, 64'h1_0000_0124);
    put(32'h00605025, 64'h128); tick();
    chk("alias_r3_64", rsData64, 64'hABCD);
    chk("noalias_r3_32", rs_data, 32'h0);

    // mixed sequence checked by the model: rt-use hazard, non-hazards, all opcode classes
    seqTab = '{32'h8C220004, 32'hAC220000, 32'h8C220004, 32'h20220001,
               32'h8C200000, 32'h00001820, 32'h10220003, 32'h14220003,
               32'h08000040, 32'h3C0B1234, 32'h280CFFFF, 32'h8C220004};
    for (int k = 0; k < 12; k++) issue(seqTab[k], 64'h200 + 64'(4 * k));
    validIn = 1'b0; tick();

    // reset abandons a stall
    put(32'h8C220004, 64'h300); tick();
    put(32'h00441820, 64'h304); reset = 1'b1; #1;
    chk("rst_stall_ready", ready_out, 1'b1);
    tick();
    chk("rst_stall_valid", valid_ex, 1'b0);
    chk("rst_stall_aluop", alu_op, 4'b0010);
    chk("rst_stall_memread", mem_read, 1'b0);
    reset = 1'b0; validIn = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised successor of the MIPS decode stage, sitting between IF and EX.
- Decodes one instruction per cycle and reads operands from an internal register file (write-first bypass from WB).
- Detects load-use hazards, stalls IF, and inserts bubbles into EX.
- Registers all decoded fields into the ID/EX boundary with a valid bit; the old nop flag becomes an explicit valid/flush/stall handshake.

Parameters:
- DATA_W, 32: register, PC and immediate width; must be >= 32.
- REG_COUNT, 32: architectural registers, power of two, 2..32; ADDR_W = clog2(REG_COUNT), all register-address ports are 5 bits and upper bits above ADDR_W are ignored.
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes.

Ports:
- clock  in  1  rising-edge clock; reset  in  1  synchronous, active-high
- instr  in  32  instruction from IF
- pc_id  in  DATA_W  PC+4 of instr
- valid_in  in  1  instr is real (0 = bubble from IF)
- flush  in  1  taken branch/jump resolved downstream; kill ID contents
- wb_we  in  1  register write enable from WB
- wb_addr  in  5  WB destination register
- wb_data  in  DATA_W  WB write data
- ready_out  out  1  0 = IF must hold instr/pc_id (stall)
- valid_ex  out  1  EX-stage contents are a real instruction
- pc_ex  out  DATA_W  registered pc_id
- rs_data, rt_data  out  DATA_W  operand values
- imm_ext  out  DATA_W  sign-extended instr[15:0]; zero-extended for andi/ori
- rs_ex, rt_ex  out  5  source register numbers, for forwarding
- rd_ex  out  5  destination: instr[15:11] for R-type, else instr[20:16]
- alu_op  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1000 LUI, 1111 FUNCT
- alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, branch_ne, jump  out  1 each
- illegal_ex  out  1  unknown opcode captured

Behaviour:
- Reset: all outputs 0 except alu_op=0010; all registers cleared to 0; ready_out=1.
- Latency: single-cycle registered. Inputs sampled at edge N appear on outputs after edge N; the register-file read is combinational.
- Decode table:
  - 000000 R-type: reg_write, alu_op=FUNCT.
  - 100011 lw: alu_src, mem_read, mem_to_reg, reg_write, ADD.
  - 101011 sw: alu_src, mem_write, ADD.
  - 000100 beq: branch, SUB. 000101 bne: branch, branch_ne, SUB.
  - 000010 j: jump.
  - 001000 addi: ADD. 001100 andi: AND. 001101 ori: OR. 001010 slti: SLT. 001111 lui: LUI.
  - All I-type ALU ops (addi through lui) set alu_src and reg_write.
- Illegal opcode: any other opcode is captured with valid_ex=0 and illegal_ex=1 for one cycle; all controls 0.
- rt_used: asserted for R-type, sw, beq and bne.
- Register file: REG_COUNT x DATA_W.
  - Write on the clock edge when wb_we=1.
  - Write-first bypass: if wb_we && wb_addr==read address (and the address is not 0 when ZERO_REG), the read returns wb_data in the same cycle.
  - With ZERO_REG=1, register 0 always reads 0.
- Load-use hazard (combinational):
  - Condition: hz = valid_in && valid_ex && mem_read && rd_ex!=0 && (rd_ex==instr[25:21] || (rt_used && rd_ex==instr[20:16])).
  - When hz: ready_out=0, the EX registers load a bubble (valid_ex=0, all controls 0), and pc_ex/operand values are don't-care.
  - A hazard lasts exactly one cycle, since the bubble clears mem_read.
- Bubble input: valid_in=0 loads a bubble; ready_out=1.
- Flush:
  - Takes priority over hz: EX loads a bubble, ready_out=1, and the current instr is discarded.
  - The register-file write still happens during flush.
- Simultaneous events:
  - reset > flush > hz > normal.
  - A WB write is performed in the same cycle as a stall; the re-read on the replayed cycle sees the new value.
- Reset mid-stall: the stall is abandoned and outputs return to reset values on the next edge.

Test Plan:
1. Reset, then instr=0x8C220004 (lw r2,4(r1)) at pc_id=0x100 with r1=0x10 -> next cycle: valid_ex=1, mem_read=1, rd_ex=2, imm_ext=4, rs_data=0x10, pc_ex=0x100.
2. lw r2 followed by add r3,r2,r4 (0x00441820) -> ready_out=0 for 1 cycle, valid_ex=0 bubble, then add issues with rs_ex=2, alu_op=1111, rd_ex=3.
3. wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle as decoding "or r6,r5,r0" -> rs_data=0xDEADBEEF; a write to r0 reads back 0.
4. flush=1 while a lw-use hazard is present -> ready_out=1, valid_ex=0, no stall on the next cycle.
5. Opcode 0x3F -> illegal_ex=1 for one cycle, valid_ex=0; andi with imm 0x8000 -> imm_ext=0x00008000; addi with imm 0x8000 -> imm_ext=0xFFFF8000.
6. DATA_W=64, REG_COUNT=16: addi imm 0xFFFF -> imm_ext=0xFFFFFFFFFFFFFFFF; wb_addr=0x13 aliases to register 3.
